// File: rtl/p2_action_sequencer.sv
// Player-2 AI action sequencer: samples the AI action once per frame and turns it
// into held movement levels or short attack presses followed by a cooldown.
module p2_action_sequencer #(
  parameter int unsigned HOLD_FRAMES     = 8,
  parameter int unsigned ATTACK_FRAMES   = 1,
  parameter int unsigned COOLDOWN_FRAMES = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       ai_enable,
  input  logic       p2_busy,
  input  logic [2:0] action_in,
  output logic       p2_left,
  output logic       p2_right,
  output logic       p2_attack,
  output logic       p2_dir_attack,
  output logic       ai_ready
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] HOLD_LOAD     = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [CNT_W-1:0] ATTACK_LOAD   = CNT_W'(ATTACK_FRAMES - 1);
  localparam logic [CNT_W-1:0] COOLDOWN_LOAD = CNT_W'(COOLDOWN_FRAMES - 1);

  typedef enum logic [2:0] {
    ST_DISABLED,
    ST_SAMPLE,
    ST_HOLD,
    ST_ATTACK,
    ST_COOLDOWN
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             left_q, right_q, attack_q, dir_q, ready_q;

  logic dec_left_c, dec_right_c, dec_attack_c, dec_dir_c;

  // Action decode, biased toward movement (5..7 alias idle/left/right).
  always_comb begin
    dec_left_c   = 1'b0;
    dec_right_c  = 1'b0;
    dec_attack_c = 1'b0;
    dec_dir_c    = 1'b0;
    case (action_in)
      3'd1, 3'd6: dec_left_c   = 1'b1;
      3'd2, 3'd7: dec_right_c  = 1'b1;
      3'd3:       dec_attack_c = 1'b1;
      3'd4:       dec_dir_c    = 1'b1;
      default:    ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset || !ai_enable) begin
      state_q  <= ST_DISABLED;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      attack_q <= 1'b0;
      dir_q    <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_DISABLED: begin
          state_q <= ST_SAMPLE;
          ready_q <= 1'b1;
        end
        ST_SAMPLE: begin
          if (frame_tick && !p2_busy) begin
            ready_q  <= 1'b0;
            left_q   <= dec_left_c;
            right_q  <= dec_right_c;
            attack_q <= dec_attack_c;
            dir_q    <= dec_dir_c;
            if (dec_attack_c || dec_dir_c) begin
              state_q <= ST_ATTACK;
              cnt_q   <= ATTACK_LOAD;
            end else begin
              state_q <= ST_HOLD;
              cnt_q   <= HOLD_LOAD;
            end
          end
        end
        ST_HOLD: begin
          if (frame_tick) begin
            if (cnt_q == '0) begin
              state_q <= ST_SAMPLE;
              left_q  <= 1'b0;
              right_q <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        ST_ATTACK: begin
          if (frame_tick) begin
            if (cnt_q == '0) begin
              state_q  <= ST_COOLDOWN;
              cnt_q    <= COOLDOWN_LOAD;
              attack_q <= 1'b0;
              dir_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        ST_COOLDOWN: begin
          if (frame_tick) begin
            if (cnt_q == '0) begin
              state_q <= ST_SAMPLE;
              ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
        default: begin
          state_q  <= ST_DISABLED;
          cnt_q    <= '0;
          left_q   <= 1'b0;
          right_q  <= 1'b0;
          attack_q <= 1'b0;
          dir_q    <= 1'b0;
          ready_q  <= 1'b0;
        end
      endcase
    end
  end

  assign p2_left       = left_q;
  assign p2_right      = right_q;
  assign p2_attack     = attack_q;
  assign p2_dir_attack = dir_q;
  assign ai_ready      = ready_q;

endmodule

// File: tb/tb_p2_action_sequencer.sv
// Bench for p2_action_sequencer: default instance plus a short-timing instance, a
// directed vector table, hand sequences and a random run against a frame-count model.
module tb_p2_action_sequencer;

  logic       clk;
  logic       rst_n, ai_en, tick, busy;
  logic [2:0] act;

  logic l0, r0, a0, d0, y0;
  logic l1, r1, a1, d1, y1;
  logic [4:0] dout [2];

  int checks = 0;
  int errors = 0;
  bit chk_on = 0;

  // Model state: frames counted since enable, tick of last sample, sampled code.
  int         mh [2] = '{8, 3};
  int         ma [2] = '{1, 3};
  int         mc [2] = '{12, 2};
  bit         m_dis [2] = '{1'b1, 1'b1};
  bit         m_rdy [2] = '{1'b0, 1'b0};
  bit         m_act [2] = '{1'b0, 1'b0};
  int         m_t [2] = '{0, 0};
  int         m_s [2] = '{0, 0};
  logic [2:0] m_a [2] = '{3'd0, 3'd0};

  bit ed_rst, ed_en, ed_tick;
  logic [4:0] prev [2];

  typedef struct {
    bit         rst_n;
    bit         en;
    bit         tick;
    bit         busy;
    logic [2:0] act;
    logic [4:0] exp;
  } vec_t;
  vec_t tv [25];

  p2_action_sequencer dut (
    .clk(clk), .reset(rst_n), .frame_tick(tick), .ai_enable(ai_en), .p2_busy(busy),
    .action_in(act), .p2_left(l0), .p2_right(r0), .p2_attack(a0), .p2_dir_attack(d0),
    .ai_ready(y0)
  );

  p2_action_sequencer #(.HOLD_FRAMES(3), .ATTACK_FRAMES(3), .COOLDOWN_FRAMES(2)) dut3 (
    .clk(clk), .reset(rst_n), .frame_tick(tick), .ai_enable(ai_en), .p2_busy(busy),
    .action_in(act), .p2_left(l1), .p2_right(r1), .p2_attack(a1), .p2_dir_attack(d1),
    .ai_ready(y1)
  );

  assign dout[0] = {l0, r0, a0, d0, y0};
  assign dout[1] = {l1, r1, a1, d1, y1};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check5(input string nm, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got {L,R,A,D,RDY}=%b expected %b", nm, $time, got, exp);
    end
  endtask

  task automatic check1(input string nm, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", nm, $time, got, exp);
    end
  endtask

  function automatic bit is_atk(input logic [2:0] a);
    return (a == 3'd3) || (a == 3'd4);
  endfunction

  function automatic logic [4:0] model_out(input int m);
    logic [4:0] o;
    int d;
    o = {4'b0000, m_rdy[m]};
    if (m_act[m]) begin
      d = m_t[m] - m_s[m];
      case (m_a[m])
        3'd1, 3'd6: o[4] = 1'b1;
        3'd2, 3'd7: o[3] = 1'b1;
        3'd3:       o[2] = (d < ma[m]);
        3'd4:       o[1] = (d < ma[m]);
        default:    ;
      endcase
    end
    return o;
  endfunction

  task automatic model_step(input int m);
    int len;
    if (!rst_n || !ai_en) begin
      m_dis[m] = 1'b1;
      m_act[m] = 1'b0;
      m_rdy[m] = 1'b0;
    end else if (m_dis[m]) begin
      m_dis[m] = 1'b0;
      m_rdy[m] = 1'b1;
    end else if (tick) begin
      m_t[m]++;
      if (m_rdy[m]) begin
        if (!busy) begin
          m_rdy[m] = 1'b0;
          m_act[m] = 1'b1;
          m_s[m]   = m_t[m];
          m_a[m]   = act;
        end
      end else if (m_act[m]) begin
        len = is_atk(m_a[m]) ? ma[m] + mc[m] : mh[m];
        if (m_t[m] - m_s[m] >= len) begin
          m_act[m] = 1'b0;
          m_rdy[m] = 1'b1;
        end
      end
    end
  endtask

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) model_step(m);
    ed_rst  = rst_n;
    ed_en   = ai_en;
    ed_tick = tick;
  end

  // Continuous model comparison and output invariants.
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (chk_on) begin
        check5(m == 0 ? "model_dflt" : "model_short", dout[m], model_out(m));
        check1("onehot", ($countones(dout[m][4:1]) <= 1), 1'b1);
        check1("change_on_tick",
               (dout[m][4:1] == prev[m][4:1]) || ed_tick || !ed_en || !ed_rst, 1'b1);
      end
      prev[m] = dout[m];
    end
  end

  task automatic frame();
    tick = 1'b0;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  initial begin
    int nframes;
    int cyc;
    rst_n = 1'b0; ai_en = 1'b0; tick = 1'b0; busy = 1'b0; act = 3'd0;

    // Short-timing instance (HOLD=3, ATTACK=3, COOLDOWN=2), tick on most clks.
    tv[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 5'b00000};
    tv[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 5'b00001};
    tv[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd1, 5'b10000};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd1, 5'b10000};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b10000};
    tv[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b10000};
    tv[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00001};
    tv[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd2, 5'b00001};
    tv[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 5'b00100};
    tv[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00100};
    tv[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00100};
    tv[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00000};
    tv[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00000};
    tv[13] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00001};
    tv[14] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd4, 5'b00010};
    tv[15] = '{1'b1, 1'b0, 1'b1, 1'b0, 3'd4, 5'b00000};
    tv[16] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 5'b00001};
    tv[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd7, 5'b01000};
    tv[18] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'b01000};
    tv[19] = '{1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00000};
    tv[20] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 5'b00001};
    tv[21] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd5, 5'b00000};
    tv[22] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00000};
    tv[23] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00000};
    tv[24] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd0, 5'b00001};

    for (int i = 0; i < 25; i++) begin
      rst_n = tv[i].rst_n; ai_en = tv[i].en; tick = tv[i].tick;
      busy = tv[i].busy;   act = tv[i].act;
      @(negedge clk);
      check5($sformatf("vec%0d", i), dout[1], tv[i].exp);
      chk_on = 1'b1;
    end

    // Resynchronise both instances to SAMPLE.
    tick = 1'b0; busy = 1'b0; rst_n = 1'b0;
    @(negedge clk);
    check5("reset_dflt", dout[0], 5'b00000);
    rst_n = 1'b1; ai_en = 1'b1;
    @(negedge clk);
    check1("enable_ready", y0, 1'b1);

    // Movement hold: left for exactly 8 ticks.
    act = 3'd1;
    frame();
    check5("left_sample", dout[0], 5'b10000);
    for (int i = 1; i <= 8; i++) begin
      frame();
      check1($sformatf("left_hold%0d", i), l0, (i < 8));
      check1($sformatf("left_ready%0d", i), y0, (i == 8));
    end

    // Attack: one tick press then 12 quiet ticks.
    act = 3'd3;
    frame();
    check5("attack_press", dout[0], 5'b00100);
    for (int i = 1; i <= 13; i++) begin
      frame();
      check5($sformatf("cooldown%0d", i), dout[0], {4'b0000, (i == 13)});
    end

    // Busy blocks sampling.
    busy = 1'b1; act = 3'd2;
    for (int i = 0; i < 3; i++) begin
      frame();
      check5($sformatf("busy%0d", i), dout[0], 5'b00001);
    end
    busy = 1'b0;
    frame();
    check5("right_after_busy", dout[0], 5'b01000);

    // Disable on a frame_tick edge during HOLD.
    act = 3'd6;
    frame();
    check5("right_still", dout[0], 5'b01000);
    tick = 1'b1; ai_en = 1'b0;
    @(negedge clk);
    check5("disable_dflt", dout[0], 5'b00000);
    check5("disable_short", dout[1], 5'b00000);
    tick = 1'b0; ai_en = 1'b1;
    @(negedge clk);
    check5("reenable_dflt", dout[0], 5'b00001);
    check5("reenable_short", dout[1], 5'b00001);

    // Reset in the middle of a 3-frame attack.
    act = 3'd3;
    frame();
    check5("atk3_press", dout[1], 5'b00100);
    frame();
    check5("atk3_mid", dout[1], 5'b00100);
    rst_n = 1'b0;
    @(negedge clk);
    check5("atk3_reset", dout[1], 5'b00000);
    check5("atk3_reset_dflt", dout[0], 5'b00000);
    rst_n = 1'b1;
    @(negedge clk);

    // Random run checked by the model.
    nframes = 0;
    cyc = 0;
    while (nframes < 2000 && cyc < 20000) begin
      rst_n = ($urandom_range(0, 499) != 0);
      ai_en = ($urandom_range(0, 99) != 0);
      tick  = ($urandom_range(0, 2) == 0);
      busy  = ($urandom_range(0, 3) == 0);
      act   = 3'($urandom);
      @(negedge clk);
      if (tick) nframes++;
      cyc++;
    end
    check1("random_frames_done", (nframes >= 2000), 1'b1);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/p2_action_sequencer.md
# p2_action_sequencer

Converts the raw 3-bit pseudo-random action stream from the player-2 AI source into frame-paced player-2 control signals for the fighter logic. The block samples the AI action once per game frame, then holds it for a fixed number of frames. Movement is held as a level, and attacks are issued as a short press followed by a cooldown. It sits between the AI action generator and the player-2 fighter FSM, and takes the place of the player-2 button inputs when AI mode is enabled.

## Interface
Parameters:
- HOLD_FRAMES, 8: frames a movement or idle decision is held; range 1–255.
- ATTACK_FRAMES, 1: frames an attack output stays asserted; range 1–255.
- COOLDOWN_FRAMES, 12: frames with all outputs low after an attack; range 1–255.

Ports:
- clk  input  1: system clock; single clock domain.
- reset  input  1: synchronous, active-low reset.
- frame_tick  input  1: one-clk pulse per game frame.
- ai_enable  input  1: AI controls player 2 when high.
- p2_busy  input  1: the fighter FSM cannot accept a new command (mid-attack, hitstun, etc.).
- action_in  input  3: action code from the AI generator; free-running, may change every clk.
- p2_left  output  1: move left (level).
- p2_right  output  1: move right (level).
- p2_attack  output  1: basic attack press.
- p2_dir_attack  output  1: directional attack press.
- ai_ready  output  1: high in the SAMPLE state.

## Operation
Action decode (bias toward movement):
- 0, 5: idle
- 1, 6: left
- 2, 7: right
- 3: basic attack
- 4: directional attack

States:
- DISABLED, SAMPLE, HOLD, ATTACK, COOLDOWN.
- A single 8-bit frame counter `cnt` is shared by HOLD, ATTACK and COOLDOWN.

Transitions (evaluated on rising clk; reset takes priority, then ai_enable):
- reset low: state becomes DISABLED, `cnt` = 0, all outputs 0.
- ai_enable low in any state: state becomes DISABLED next clk and all outputs clear. DISABLED goes to SAMPLE on the first clk with ai_enable high.
- SAMPLE, on frame_tick && !p2_busy:
  - Register the decoded action_in.
  - Movement or idle: go to HOLD, `cnt` = HOLD_FRAMES−1, drive p2_left/p2_right per the decode.
  - Attack: go to ATTACK, `cnt` = ATTACK_FRAMES−1, drive p2_attack or p2_dir_attack.
  - frame_tick with p2_busy high: remain in SAMPLE, outputs stay 0, action_in is ignored.
- HOLD, on frame_tick:
  - `cnt` == 0: go to SAMPLE, clear outputs.
  - Otherwise `cnt` −1.
  - p2_busy is ignored in HOLD.
- ATTACK, on frame_tick:
  - `cnt` == 0: go to COOLDOWN, `cnt` = COOLDOWN_FRAMES−1, clear outputs.
  - Otherwise `cnt` −1.
- COOLDOWN, on frame_tick: `cnt` == 0 goes to SAMPLE; otherwise `cnt` −1.
- States only advance on frame_tick; clks without frame_tick hold state and outputs.

Output invariants:
- At most one of p2_left, p2_right, p2_attack, p2_dir_attack is high at any time.
- Outputs are registered; there are no combinational paths from inputs.

## Timing
- Reset values: p2_left = p2_right = p2_attack = p2_dir_attack = 0, ai_ready = 0, state = DISABLED.
- Sample latency: action_in is captured on the clk edge where frame_tick is high in SAMPLE. Outputs are valid on that same edge, i.e. visible in the following cycle.
- Movement/idle decision made at tick k:
  - Outputs stay high through the edge of tick k+HOLD_FRAMES, which clears them.
  - SAMPLE is entered at that edge, so the next sample occurs at tick k+HOLD_FRAMES+1.
- Attack at tick k:
  - Asserted for exactly ATTACK_FRAMES ticks.
  - Then COOLDOWN_FRAMES ticks with all outputs low.
  - Next sample at tick k+ATTACK_FRAMES+COOLDOWN_FRAMES+1.
- ai_ready is high in SAMPLE and DISABLED→SAMPLE completes in 1 clk.
- Boundary conditions:
  - ai_enable falling on the same edge as frame_tick: disable wins.
  - Reset mid-HOLD: outputs clear on that edge.
  - Counter never wraps: reload values are ≤254 and it only decrements from a nonzero value.

## Test plan
- Reset, then ai_enable=1, action_in=1, frame_tick every 4 clks: p2_left high for exactly 8 ticks, then low; next sample at tick 9.
- action_in=3 at sample: p2_attack high for 1 tick, then 12 ticks all-low, ai_ready high again after tick 13; p2_right/p2_left stay 0 throughout.
- p2_busy=1 during 3 ticks in SAMPLE with action_in=2: no outputs, ai_ready stays 1. p2_busy drops and action_in=2 is sampled at the next tick: p2_right high.
- During HOLD with action_in=6, drop ai_enable on a frame_tick clk: all outputs 0 next clk, state DISABLED. Re-enable: ai_ready=1 after 1 clk.
- Assert reset low mid-ATTACK with ATTACK_FRAMES=3: outputs 0 next edge and ai_ready=0.
- Random action_in for 2000 frames: one-hot-or-zero output invariant holds; outputs only change on frame_tick or disable/reset edges.
